// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit execution unit: single-cycle ALU ops plus an iterative
// shift-and-add multiply, with a registered, backpressurable result stage.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_SLL  = 4'b1010,
        OP_SRL  = 4'b1101,
        OP_SRA  = 4'b1110
    } op_t;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t            state, state_n;
    logic              out_valid_n, zero_flag_n;
    logic [WIDTH-1:0]  result_n;
    logic [WIDTH-1:0]  acc, acc_n, mcand, mcand_n, mplier, mplier_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  alu_res, acc_sum;
    logic [SHW-1:0]    shamt;
    logic              accept;

    assign shamt    = rs2[SHW-1:0];
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_sum  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        unique case (sel)
            OP_ADD:  alu_res = rs1 + rs2;
            OP_SUB:  alu_res = rs1 - rs2;
            OP_AND:  alu_res = rs1 & rs2;
            OP_OR:   alu_res = rs1 | rs2;
            OP_XOR:  alu_res = rs1 ^ rs2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, rs1 < rs2};
            OP_SLL:  alu_res = rs1 << shamt;
            OP_SRL:  alu_res = rs1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(rs1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted to its current value first,
        // so no path through the case below can leave one unassigned (no latches).
        state_n     = state;
        out_valid_n = out_valid;
        result_n    = result;
        zero_flag_n = zero_flag;
        acc_n       = acc;
        mcand_n     = mcand;
        mplier_n    = mplier;
        cnt_n       = cnt;

        unique case (state)
            IDLE: begin
                if (out_valid && out_ready)
                    out_valid_n = 1'b0;
                if (accept) begin
                    if (sel == OP_MUL) begin
                        acc_n    = '0;
                        mcand_n  = rs1;
                        mplier_n = rs2;
                        cnt_n    = CW'(WIDTH);
                        state_n  = MUL;
                    end else begin
                        result_n    = alu_res;
                        zero_flag_n = (alu_res == '0);
                        out_valid_n = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_n    = acc_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt - CW'(1);
                // Last iteration: publish the sum including this cycle's partial product.
                if (cnt == CW'(1)) begin
                    result_n    = acc_sum;
                    zero_flag_n = (acc_sum == '0);
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: multiplier datapath is cleared too, so an aborted MUL leaves no residue.
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            result    <= result_n;
            zero_flag <= zero_flag_n;
            acc       <= acc_n;
            mcand     <= mcand_n;
            mplier    <= mplier_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors and corner sequences on an
// 8-bit instance, randomised scoreboard runs on 8- and 32-bit instances.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid[2];
    logic        out_ready[2];
    logic [3:0]  sel[2];
    logic [31:0] rs1[2];
    logic [31:0] rs2[2];

    logic        in_ready8, out_valid8, zero_flag8;
    logic [7:0]  result8;
    logic        in_ready32, out_valid32, zero_flag32;
    logic [31:0] result32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready8), .sel(sel[0]),
        .rs1(rs1[0][7:0]), .rs2(rs2[0][7:0]),
        .out_valid(out_valid8), .out_ready(out_ready[0]),
        .result(result8), .zero_flag(zero_flag8)
    );

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready32), .sel(sel[1]),
        .rs1(rs1[1]), .rs2(rs2[1]),
        .out_valid(out_valid32), .out_ready(out_ready[1]),
        .result(result32), .zero_flag(zero_flag32)
    );

    function automatic logic f_ir(int d); return d == 0 ? in_ready8  : in_ready32;  endfunction
    function automatic logic f_ov(int d); return d == 0 ? out_valid8 : out_valid32; endfunction
    function automatic logic f_zf(int d); return d == 0 ? zero_flag8 : zero_flag32; endfunction
    function automatic logic [31:0] f_res(int d);
        return d == 0 ? {24'd0, result8} : result32;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values, masked back to w bits.
    function automatic logic [31:0] model(logic [3:0] s, logic [31:0] a, logic [31:0] b, int w);
        longint m, ua, ub, sa, sb, r;
        int sh;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        sh = int'(ub % longint'(w));
        case (s)
            4'b0000: r = ua + ub;
            4'b0001: r = ua - ub;
            4'b0111: r = ua & ub;
            4'b0110: r = ua | ub;
            4'b0100: r = ua ^ ub;
            4'b0010: r = (sa < sb) ? 1 : 0;
            4'b0011: r = (ua < ub) ? 1 : 0;
            4'b1010: r = ua << sh;
            4'b1101: r = ua >> sh;
            4'b1110: r = sa >>> sh;
            4'b1000: r = ua * ub;
            default: r = 0;
        endcase
        return 32'(r & m);
    endfunction

    // Issue one op with out_ready=1; report result, edges after acceptance until
    // out_valid, and how many of those cycles had in_ready low.
    task automatic run_op(int d, logic [3:0] s, logic [31:0] a, logic [31:0] b,
                          output logic [31:0] r, output logic zf,
                          output int extra, output int low);
        int g;
        @(negedge clk);
        in_valid[d] = 1'b1; sel[d] = s; rs1[d] = a; rs2[d] = b; out_ready[d] = 1'b1;
        #1;
        g = 0;
        while (!f_ir(d) && g < 50) begin
            @(negedge clk); #1; g++;
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        #1;
        extra = 0;
        low   = 0;
        while (!f_ov(d) && extra < 100) begin
            if (!f_ir(d)) low++;
            @(negedge clk); #1; extra++;
        end
        r  = f_res(d);
        zf = f_zf(d);
    endtask

    task automatic rand_run(int d, int w, int n);
        logic [31:0] q[$];
        logic [31:0] mask, exp;
        int cyc;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'((longint'(1) << w) - 1);
        cyc  = 0;
        while (cyc < n || (q.size() > 0 && cyc < n + 200)) begin
            @(negedge clk);
            if (cyc < n) begin
                in_valid[d]  = 1'($urandom_range(0, 1));
                out_ready[d] = ($urandom_range(0, 3) != 0);
                sel[d]       = 4'($urandom_range(0, 15));
                rs1[d]       = $urandom & mask;
                rs2[d]       = ($urandom_range(0, 7) == 0) ? rs1[d] : ($urandom & mask);
            end else begin
                in_valid[d]  = 1'b0;
                out_ready[d] = 1'b1;
            end
            #1;
            if (f_ov(d) && out_ready[d]) begin
                if (q.size() == 0) begin
                    check($sformatf("rand%0d_spurious_result", w), 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check($sformatf("rand%0d_result", w), f_res(d), exp);
                    check($sformatf("rand%0d_zero_flag", w), 32'(f_zf(d)), 32'(exp == 0));
                end
            end
            if (in_valid[d] && f_ir(d))
                q.push_back(model(sel[d], rs1[d], rs2[d], w));
            cyc++;
        end
        check($sformatf("rand%0d_pending_left", w), q.size(), 0);
        @(negedge clk); #1;
        check($sformatf("rand%0d_idle_out_valid", w), 32'(f_ov(0 + d)), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] r;
        logic        zf;
        int          extra, low, stale;

        vecs[0]  = '{4'b0000, 32'hFF, 32'h01, 32'h00, 1'b1};  // ADD wrap
        vecs[1]  = '{4'b0001, 32'h05, 32'h07, 32'hFE, 1'b0};  // SUB borrow
        vecs[2]  = '{4'b1111, 32'h5A, 32'h33, 32'h00, 1'b1};  // unknown code
        vecs[3]  = '{4'b0010, 32'hFF, 32'h01, 32'h01, 1'b0};  // SLT -1 < 1
        vecs[4]  = '{4'b0011, 32'hFF, 32'h01, 32'h00, 1'b1};  // SLTU 255 < 1
        vecs[5]  = '{4'b1110, 32'h80, 32'h0B, 32'hF0, 1'b0};  // SRA, amount 3
        vecs[6]  = '{4'b1101, 32'h80, 32'h03, 32'h10, 1'b0};  // SRL
        vecs[7]  = '{4'b1010, 32'h01, 32'h07, 32'h80, 1'b0};  // SLL
        vecs[8]  = '{4'b1000, 32'h0D, 32'h0B, 32'h8F, 1'b0};  // MUL
        vecs[9]  = '{4'b1000, 32'hFF, 32'hFF, 32'h01, 1'b0};  // MUL wrap
        vecs[10] = '{4'b0111, 32'hF0, 32'h3C, 32'h30, 1'b0};  // AND
        vecs[11] = '{4'b0110, 32'hF0, 32'h0C, 32'hFC, 1'b0};  // OR
        vecs[12] = '{4'b0100, 32'hFF, 32'hFF, 32'h00, 1'b1};  // XOR to zero

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; sel[d] = 4'd0; rs1[d] = '0; rs2[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid8), 32'd0);
        check("reset_result", f_res(0), 32'd0);
        check("reset_zero_flag", 32'(zero_flag8), 32'd0);
        check("reset_in_ready8", 32'(in_ready8), 32'd1);
        check("reset_in_ready32", 32'(in_ready32), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(0, vecs[i].sel, vecs[i].a, vecs[i].b, r, zf, extra, low);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_zero_flag", i), 32'(zf), 32'(vecs[i].zf));
            check($sformatf("vec%0d_latency", i), extra, (vecs[i].sel == 4'b1000) ? 8 : 0);
            check($sformatf("vec%0d_ready_low", i), low, (vecs[i].sel == 4'b1000) ? 8 : 0);
        end

        // Back-to-back ADDs, then backpressure with an op waiting.
        @(negedge clk);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel[0] = 4'b0000; rs1[0] = 32'(i * 16 + 1); rs2[0] = 32'(i + 2);
            @(negedge clk); #1;
            check($sformatf("b2b%0d_out_valid", i), 32'(out_valid8), 32'd1);
            check($sformatf("b2b%0d_result", i), f_res(0), 32'(i * 16 + 1 + i + 2));
        end
        rs1[0] = 32'h07; rs2[0] = 32'h07; out_ready[0] = 1'b0;
        #1;
        check("hold_in_ready", 32'(in_ready8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("hold%0d_result", i), f_res(0), 32'h36);
            check($sformatf("hold%0d_out_valid", i), 32'(out_valid8), 32'd1);
            check($sformatf("hold%0d_in_ready", i), 32'(in_ready8), 32'd0);
        end
        out_ready[0] = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready8), 32'd1);
        @(negedge clk); #1;
        check("release_result", f_res(0), 32'h0E);
        check("release_out_valid", 32'(out_valid8), 32'd1);
        in_valid[0] = 1'b0;
        @(negedge clk); #1;
        check("drain_out_valid", 32'(out_valid8), 32'd0);

        // Reset three cycles into a multiply.
        in_valid[0] = 1'b1; sel[0] = 4'b1000; rs1[0] = 32'h0D; rs2[0] = 32'h0B;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_mul_in_ready", 32'(in_ready8), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mul_out_valid", 32'(out_valid8), 32'd0);
        check("rst_mul_result", f_res(0), 32'd0);
        check("rst_mul_zero_flag", 32'(zero_flag8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready8), 32'd1);
        run_op(0, 4'b0000, 32'h02, 32'h03, r, zf, extra, low);
        check("post_rst_add_result", r, 32'h05);
        check("post_rst_add_latency", extra, 0);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (out_valid8) stale++;
        end
        check("post_rst_no_stale", stale, 0);

        rand_run(0, 8, 3000);
        rand_run(1, 32, 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
